// File: rtl/cp0_irq_ctrl_if.sv
// CP0 interrupt handshake: request/ID toward CP0, trap-taken/ERET back.
// master = interrupt controller side, slave = CP0 side.
interface cp0_irq_ctrl_if #(
  parameter int ID_W = 2
) ();
  logic            irq_req;
  logic [ID_W-1:0] irq_id;
  logic            cp0_jump_en;
  logic            eret;

  modport master (
    output irq_req,
    output irq_id,
    input  cp0_jump_en,
    input  eret
  );

  modport slave (
    input  irq_req,
    input  irq_id,
    output cp0_jump_en,
    output eret
  );
endinterface

// File: rtl/cp0_irq_ctrl.sv
// Edge-detecting, maskable, fixed-priority interrupt front end for CP0.
// Ports: clk, rst (sync, active-high), irq_src, mask_we/mask_wdata,
//   global_en, cp0 (irq_req/irq_id out, cp0_jump_en/eret in),
//   busy, pending, mask, irq_count (saturating delivered count).
module cp0_irq_ctrl #(
  parameter int NUM_IRQ = 4,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               global_en,
  cp0_irq_ctrl_if.master     cp0,
  output logic               busy,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] mask,
  output logic [15:0]        irq_count
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_IRQ-1:0] prev_q;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               req_q;
  logic               busy_q;

  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] elig;
  logic [NUM_IRQ-1:0] clr;
  logic [ID_W-1:0]    win;
  logic               take;

  assign rise = irq_src & ~prev_q;
  assign elig = pend_q & mask_q & {NUM_IRQ{global_en}};

  // ERET has priority in CP0, so a jump alongside ERET is not our trap.
  assign take = (state_q == REQ) && cp0.cp0_jump_en && !cp0.eret;
  assign clr  = take ? (NUM_IRQ'(1) << id_q) : '0;

  // Scan downward so the lowest eligible index is the last one written.
  always_comb begin
    win = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) win = ID_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    mask_d  = mask_we ? mask_wdata : mask_q;
    // A rise in the clear cycle wins over the clear.
    pend_d  = (pend_q & ~clr) | rise;
    unique case (state_q)
      IDLE: begin
        if (|elig) begin
          id_d    = win;
          state_d = REQ;
        end
      end
      REQ: begin
        if (take) begin
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          state_d = SERVICE;
        end else if (!global_en) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (cp0.eret) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prev_q  <= '0;
      pend_q  <= '0;
      mask_q  <= '1;
      id_q    <= '0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= irq_src;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      req_q   <= (state_d == REQ);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign cp0.irq_req = req_q;
  assign cp0.irq_id  = id_q;
  assign busy        = busy_q;
  assign pending     = pend_q;
  assign mask        = mask_q;
  assign irq_count   = cnt_q;

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// Directed bench for cp0_irq_ctrl.
// Hand-computed vectors, one check task, single summary line.
module tb_cp0_irq_ctrl;

  localparam int N  = 4;
  localparam int IW = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] irq_src;
  logic         mask_we;
  logic [N-1:0] mask_wdata;
  logic         global_en;
  logic         busy;
  logic [N-1:0] pending;
  logic [N-1:0] mask;
  logic [15:0]  irq_count;

  int n_chk  = 0;
  int n_fail = 0;

  cp0_irq_ctrl_if #(.ID_W(IW)) cp0 ();

  cp0_irq_ctrl #(
    .NUM_IRQ(N),
    .ID_W   (IW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .irq_src   (irq_src),
    .mask_we   (mask_we),
    .mask_wdata(mask_wdata),
    .global_en (global_en),
    .cp0       (cp0.master),
    .busy      (busy),
    .pending   (pending),
    .mask      (mask),
    .irq_count (irq_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag,
                           input logic req,
                           input logic bsy,
                           input logic [IW-1:0] id);
    chk({tag, ".req"}, 32'(cp0.irq_req), 32'(req));
    chk({tag, ".busy"}, 32'(busy), 32'(bsy));
    chk({tag, ".id"}, 32'(cp0.irq_id), 32'(id));
  endtask

  initial begin
    rst             = 1'b1;
    irq_src         = '0;
    mask_we         = 1'b0;
    mask_wdata      = '0;
    global_en       = 1'b0;
    cp0.cp0_jump_en = 1'b0;
    cp0.eret        = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk_state("rst", 1'b0, 1'b0, 2'd0);
    chk("rst.pend", 32'(pending), 32'h0);
    chk("rst.mask", 32'(mask), 32'hF);
    chk("rst.cnt", 32'(irq_count), 32'h0);

    // single source
    global_en = 1'b1;
    irq_src   = 4'h4;
    step();
    chk("s.pend0", 32'(pending), 32'h4);
    chk("s.req0", 32'(cp0.irq_req), 32'h0);
    step();
    chk_state("s.req1", 1'b1, 1'b1, 2'd2);
    step();
    step();
    step();
    chk_state("s.hold", 1'b1, 1'b1, 2'd2);
    cp0.cp0_jump_en = 1'b1;
    step();
    cp0.cp0_jump_en = 1'b0;
    chk_state("s.svc", 1'b0, 1'b1, 2'd2);
    chk("s.pend", 32'(pending), 32'h0);
    chk("s.cnt", 32'(irq_count), 32'd1);
    step();
    step();
    step();
    cp0.eret = 1'b1;
    step();
    cp0.eret = 1'b0;
    chk("s.idle", 32'(busy), 32'h0);
    step();
    chk("s.level", 32'(pending), 32'h0);
    chk("s.noreq", 32'(cp0.irq_req), 32'h0);
    irq_src = '0;

    // priority and masking
    mask_we    = 1'b1;
    mask_wdata = 4'hD;
    step();
    mask_we = 1'b0;
    chk("p.mask", 32'(mask), 32'hD);
    irq_src = 4'hA;
    step();
    chk("p.pend", 32'(pending), 32'hA);
    step();
    chk_state("p.req3", 1'b1, 1'b1, 2'd3);
    cp0.cp0_jump_en = 1'b1;
    step();
    cp0.cp0_jump_en = 1'b0;
    chk("p.pend2", 32'(pending), 32'h2);
    chk("p.cnt", 32'(irq_count), 32'd2);
    mask_we    = 1'b1;
    mask_wdata = 4'hF;
    step();
    mask_we = 1'b0;
    chk_state("p.svc", 1'b0, 1'b1, 2'd3);
    cp0.eret = 1'b1;
    step();
    cp0.eret = 1'b0;
    chk("p.idle", 32'(busy), 32'h0);
    step();
    chk_state("p.req1", 1'b1, 1'b1, 2'd1);
    cp0.cp0_jump_en = 1'b1;
    step();
    cp0.cp0_jump_en = 1'b0;
    chk("p.cnt3", 32'(irq_count), 32'd3);
    cp0.eret = 1'b1;
    step();
    cp0.eret = 1'b0;
    irq_src  = '0;

    // withdraw
    irq_src = 4'h1;
    step();
    step();
    chk_state("w.req", 1'b1, 1'b1, 2'd0);
    global_en = 1'b0;
    step();
    chk_state("w.drop", 1'b0, 1'b0, 2'd0);
    chk("w.pend", 32'(pending), 32'h1);
    chk("w.cnt", 32'(irq_count), 32'd3);
    step();
    chk("w.stay", 32'(busy), 32'h0);
    global_en = 1'b1;
    step();
    chk_state("w.rereq", 1'b1, 1'b1, 2'd0);

    // set beats clear on the take cycle
    irq_src = 4'h0;
    step();
    irq_src         = 4'h1;
    cp0.cp0_jump_en = 1'b1;
    step();
    cp0.cp0_jump_en = 1'b0;
    chk("sc.pend", 32'(pending), 32'h1);
    chk("sc.cnt", 32'(irq_count), 32'd4);
    chk_state("sc.svc", 1'b0, 1'b1, 2'd0);
    cp0.eret = 1'b1;
    step();
    cp0.eret = 1'b0;
    step();
    chk_state("sc.req2", 1'b1, 1'b1, 2'd0);

    // eret alongside jump in REQ is not a take
    cp0.eret        = 1'b1;
    cp0.cp0_jump_en = 1'b1;
    step();
    cp0.eret = 1'b0;
    chk_state("e.req", 1'b1, 1'b1, 2'd0);
    chk("e.cnt", 32'(irq_count), 32'd4);
    step();
    cp0.cp0_jump_en = 1'b0;
    chk("e.cnt5", 32'(irq_count), 32'd5);
    chk("e.pend", 32'(pending), 32'h0);
    cp0.eret = 1'b1;
    step();
    chk("e.idle", 32'(busy), 32'h0);
    step();
    cp0.eret = 1'b0;
    chk_state("e.idle2", 1'b0, 1'b0, 2'd0);
    chk("e.cnt5b", 32'(irq_count), 32'd5);

    // reset in SERVICE
    irq_src = 4'h0;
    step();
    irq_src = 4'h1;
    step();
    step();
    chk_state("r.req", 1'b1, 1'b1, 2'd0);
    cp0.cp0_jump_en = 1'b1;
    step();
    cp0.cp0_jump_en = 1'b0;
    irq_src    = 4'h7;
    mask_we    = 1'b1;
    mask_wdata = 4'h3;
    step();
    mask_we = 1'b0;
    chk("r.pend", 32'(pending), 32'h6);
    chk("r.mask3", 32'(mask), 32'h3);
    rst     = 1'b1;
    irq_src = 4'h0;
    step();
    rst = 1'b0;
    chk_state("r.rst", 1'b0, 1'b0, 2'd0);
    chk("r.pend0", 32'(pending), 32'h0);
    chk("r.mask", 32'(mask), 32'hF);
    chk("r.cnt", 32'(irq_count), 32'h0);

    // saturation
    force dut.cnt_q = 16'hFFFF;
    step();
    release dut.cnt_q;
    step();
    chk("sat.pre", 32'(irq_count), 32'hFFFF);
    irq_src = 4'h8;
    step();
    step();
    chk_state("sat.req", 1'b1, 1'b1, 2'd3);
    cp0.cp0_jump_en = 1'b1;
    step();
    cp0.cp0_jump_en = 1'b0;
    chk("sat.cnt", 32'(irq_count), 32'hFFFF);
    chk("sat.svc", 32'(busy), 32'h1);
    cp0.eret = 1'b1;
    step();
    cp0.eret = 1'b0;
    chk("sat.idle", 32'(busy), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
